// File: rtl/regbank_mwr.sv
// regbank_mwr -- multi-write / multi-read architectural register bank with a
// tagged valid scoreboard.
//
// Storage is a live-value-table arrangement: each write port owns one simple
// dual-port RAM copy per read port (one write, one registered read), and a
// per-register LVT remembers which write port delivered the latest value.
// A writeback is only accepted when its tag matches the register's current
// expected producer tag, so late writebacks from squashed/re-allocated
// producers are silently dropped.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   write_en/addr/data/tag  [WRITE_PORTS] writeback buses
//   alloc_en/addr/tag   destination allocation from issue
//   read_addr           [READ_PORTS] read addresses, sampled at the edge
//   read_data           [READ_PORTS] read results, one cycle after address
//   register_valid      per-register "final value present" bit
//   reg_tag_out         per-register expected producer tag
module regbank_mwr #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter int TWIDTH      = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [WRITE_PORTS-1:0]                    write_en,
    input  logic [WRITE_PORTS-1:0][AWIDTH-1:0]        write_addr,
    input  logic [WRITE_PORTS-1:0][DWIDTH-1:0]        write_data,
    input  logic [WRITE_PORTS-1:0][TWIDTH-1:0]        write_tag,
    input  logic                                      alloc_en,
    input  logic [AWIDTH-1:0]                         alloc_addr,
    input  logic [TWIDTH-1:0]                         alloc_tag,
    input  logic [READ_PORTS-1:0][AWIDTH-1:0]         read_addr,
    output logic [READ_PORTS-1:0][DWIDTH-1:0]         read_data,
    output logic [2**AWIDTH-1:0]                      register_valid,
    output logic [2**AWIDTH-1:0][TWIDTH-1:0]          reg_tag_out
);

    localparam int NREG = 2**AWIDTH;
    localparam int PW   = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1;

    genvar gi, gj;

    // ------------------------------------------------------------------
    // Write acceptance: enabled, not x0, and tag matches the pre-edge tag.
    // ------------------------------------------------------------------
    logic [WRITE_PORTS-1:0] accept;

    generate
        for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_accept
            assign accept[gi] = write_en[gi]
                             && (write_addr[gi] != '0)
                             && (write_tag[gi] == reg_tag_out[write_addr[gi]]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scoreboard: one valid bit and tag per register; x0 is constant.
    // Allocation is applied after the writeback so it wins when both hit
    // the same register in the same cycle.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign register_valid[gi] = 1'b1;
                assign reg_tag_out[gi]    = '0;
            end else begin : g_reg
                logic              valid_reg;
                logic [TWIDTH-1:0] tag_reg;
                logic              write_hit;

                always_comb begin
                    write_hit = 1'b0;
                    for (int p = 0; p < WRITE_PORTS; p++) begin
                        if (accept[p] && (write_addr[p] == AWIDTH'(gi))) begin
                            write_hit = 1'b1;
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        valid_reg <= 1'b1;
                        tag_reg   <= '0;
                    end else begin
                        if (write_hit) begin
                            valid_reg <= 1'b1;
                        end
                        if (alloc_en && (alloc_addr == AWIDTH'(gi))) begin
                            valid_reg <= 1'b0;
                            tag_reg   <= alloc_tag;
                        end
                    end
                end

                assign register_valid[gi] = valid_reg;
                assign reg_tag_out[gi]    = tag_reg;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Live value table: ascending loop so the highest accepted port wins
    // a same-address conflict. Not reset; it is only meaningful for
    // registers that have been written.
    // ------------------------------------------------------------------
    logic [PW-1:0] lvt_reg [NREG];

    always_ff @(posedge clk) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (accept[p]) begin
                lvt_reg[write_addr[p]] <= PW'(p);
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM banks: one copy per (write port, read port) pair, each a plain
    // single-write / registered-read array. Storage is never reset.
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] bank_q [WRITE_PORTS][READ_PORTS];

    generate
        for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_wbank
            for (gj = 0; gj < READ_PORTS; gj++) begin : g_rbank
                logic [DWIDTH-1:0] mem [NREG];
                logic [DWIDTH-1:0] q_reg;

                always_ff @(posedge clk) begin
                    if (accept[gi]) begin
                        mem[write_addr[gi]] <= write_data[gi];
                    end
                    q_reg <= mem[read_addr[gj]];
                end

                assign bank_q[gi][gj] = q_reg;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports: the bank read is read-before-write, so a same-cycle
    // accepted write is captured separately as a bypass value. The x0
    // check uses the registered address; reset forces the zero path so
    // read_data reads 0 after reset.
    // ------------------------------------------------------------------
    generate
        for (gj = 0; gj < READ_PORTS; gj++) begin : g_rd
            logic              byp_hit_next;
            logic [DWIDTH-1:0] byp_data_next;
            logic              byp_hit_reg;
            logic [DWIDTH-1:0] byp_data_reg;
            logic              zero_reg;
            logic [PW-1:0]     sel_reg;

            always_comb begin
                byp_hit_next  = 1'b0;
                byp_data_next = '0;
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (accept[p] && (write_addr[p] == read_addr[gj])) begin
                        byp_hit_next  = 1'b1;
                        byp_data_next = write_data[p];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    zero_reg    <= 1'b1;
                    byp_hit_reg <= 1'b0;
                end else begin
                    zero_reg    <= (read_addr[gj] == '0);
                    byp_hit_reg <= byp_hit_next;
                end
                byp_data_reg <= byp_data_next;
                sel_reg      <= lvt_reg[read_addr[gj]];
            end

            assign read_data[gj] = zero_reg    ? '0 :
                                   byp_hit_reg ? byp_data_reg :
                                                 bank_q[sel_reg][gj];
        end
    endgenerate

endmodule

// File: tb/tb_regbank_mwr.sv
module tb_regbank_mwr;

    logic              clk;
    logic              reset;
    logic [1:0]        write_en;
    logic [1:0][4:0]   write_addr;
    logic [1:0][31:0]  write_data;
    logic [1:0][3:0]   write_tag;
    logic              alloc_en;
    logic [4:0]        alloc_addr;
    logic [3:0]        alloc_tag;
    logic [1:0][4:0]   read_addr;
    logic [1:0][31:0]  read_data;
    logic [31:0]       register_valid;
    logic [31:0][3:0]  reg_tag_out;

    regbank_mwr #(
        .DWIDTH(32), .AWIDTH(5), .READ_PORTS(2), .WRITE_PORTS(2), .TWIDTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .write_tag(write_tag),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_tag(alloc_tag),
        .read_addr(read_addr), .read_data(read_data),
        .register_valid(register_valid), .reg_tag_out(reg_tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0; logic [31:0] wd0; logic [3:0] wt0;
        logic [4:0]  wa1; logic [31:0] wd1; logic [3:0] wt1;
        logic        ae;  logic [4:0]  aa;  logic [3:0] at;
        logic [4:0]  ra0; logic [4:0]  ra1;
        logic [31:0] e0;  logic [31:0] e1;
        logic [4:0]  ca;  logic        ev;  logic [3:0] et;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void v(
        input logic [1:0] we,
        input logic [4:0] wa0, input logic [31:0] wd0, input logic [3:0] wt0,
        input logic [4:0] wa1, input logic [31:0] wd1, input logic [3:0] wt1,
        input logic ae, input logic [4:0] aa, input logic [3:0] at,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] e0, input logic [31:0] e1,
        input logic [4:0] ca, input logic ev, input logic [3:0] et);
        vec_t t;
        t.we = we; t.wa0 = wa0; t.wd0 = wd0; t.wt0 = wt0;
        t.wa1 = wa1; t.wd1 = wd1; t.wt1 = wt1;
        t.ae = ae; t.aa = aa; t.at = at; t.ra0 = ra0; t.ra1 = ra1;
        t.e0 = e0; t.e1 = e1; t.ca = ca; t.ev = ev; t.et = et;
        vq.push_back(t);
    endfunction

    task automatic idle();
        write_en   = '0;
        write_addr = '0;
        write_data = '0;
        write_tag  = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        alloc_tag  = '0;
        read_addr  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        $display("reset: rd0=%h rd1=%h valid=%h", read_data[0], read_data[1], register_valid);
        chk("reset rd0", 128'(read_data[0]), 128'h0);
        chk("reset rd1", 128'(read_data[1]), 128'h0);
        chk("reset valid", 128'(register_valid), 128'hFFFF_FFFF);
        chk("reset tags", 128'(reg_tag_out), 128'h0);

        // Write x5 = 0x1234, then reset again: storage must survive.
        reset = 1'b0;
        write_en = 2'b01; write_addr[0] = 5'd5; write_data[0] = 32'h1234; write_tag[0] = 4'd0;
        step();
        idle();
        reset = 1'b1;
        read_addr[0] = 5'd5; read_addr[1] = 5'd0;
        step();
        $display("reset2: rd0=%h rd1=%h", read_data[0], read_data[1]);
        chk("reset2 rd0", 128'(read_data[0]), 128'h0);
        chk("reset2 valid", 128'(register_valid), 128'hFFFF_FFFF);
        chk("reset2 tags", 128'(reg_tag_out), 128'h0);
        reset = 1'b0;
        step();
        $display("post-reset read: rd0=%h rd1=%h", read_data[0], read_data[1]);
        chk("x5 keep rd0", 128'(read_data[0]), 128'h1234);
        chk("x0 rd1", 128'(read_data[1]), 128'h0);
        read_addr[0] = 5'd0; read_addr[1] = 5'd5;
        step();
        $display("post-reset read swap: rd0=%h rd1=%h", read_data[0], read_data[1]);
        chk("x0 rd0", 128'(read_data[0]), 128'h0);
        chk("x5 keep rd1", 128'(read_data[1]), 128'h1234);

        //  we    wa0  wd0           wt0  wa1  wd1          wt1  ae  aa  at   ra0 ra1 e0            e1           ca  ev  et
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 1, 5'd3, 4'd2, 5'd0, 5'd0, 32'h0,        32'h0,       5'd3, 0, 4'd2);
        v(2'b10, 5'd0, 32'h0,        4'd0, 5'd3, 32'hAA,     4'd2, 0, 5'd0, 4'd0, 5'd3, 5'd0, 32'hAA,       32'h0,       5'd3, 1, 4'd2);
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd0, 5'd3, 32'h0,        32'hAA,      5'd3, 1, 4'd2);
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 1, 5'd7, 4'd1, 5'd0, 5'd0, 32'h0,        32'h0,       5'd7, 0, 4'd1);
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 1, 5'd7, 4'd3, 5'd0, 5'd0, 32'h0,        32'h0,       5'd7, 0, 4'd3);
        v(2'b01, 5'd7, 32'h11,       4'd1, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd0, 5'd0, 32'h0,        32'h0,       5'd7, 0, 4'd3);
        v(2'b01, 5'd7, 32'h33,       4'd3, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd0, 5'd7, 32'h0,        32'h33,      5'd7, 1, 4'd3);
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd7, 5'd0, 32'h33,       32'h0,       5'd7, 1, 4'd3);
        v(2'b11, 5'd9, 32'h100,      4'd0, 5'd9, 32'h200,    4'd0, 0, 5'd0, 4'd0, 5'd9, 5'd0, 32'h200,      32'h0,       5'd9, 1, 4'd0);
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd9, 5'd9, 32'h200,      32'h200,     5'd9, 1, 4'd0);
        v(2'b01, 5'd9, 32'h300,      4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd0, 5'd0, 32'h0,        32'h0,       5'd9, 1, 4'd0);
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd9, 5'd5, 32'h300,      32'h1234,    5'd9, 1, 4'd0);
        v(2'b01, 5'd4, 32'hDEAD,     4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd4, 5'd0, 32'hDEAD,     32'h0,       5'd4, 1, 4'd0);
        v(2'b01, 5'd0, 32'hFF,       4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd4, 5'd0, 32'hDEAD,     32'h0,       5'd0, 1, 4'd0);
        v(2'b01, 5'd6, 32'h66,       4'd0, 5'd0, 32'h0,      4'd0, 1, 5'd6, 4'd5, 5'd0, 5'd0, 32'h0,        32'h0,       5'd6, 0, 4'd5);
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd6, 5'd0, 32'h66,       32'h0,       5'd6, 0, 4'd5);
        v(2'b01, 5'd6, 32'h77,       4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd0, 5'd6, 32'h0,        32'h66,      5'd6, 0, 4'd5);
        v(2'b11, 5'd10, 32'hA0,      4'd0, 5'd10, 32'hB0,    4'd1, 0, 5'd0, 4'd0, 5'd10, 5'd0, 32'hA0,      32'h0,       5'd10, 1, 4'd0);
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd0, 5'd10, 32'h0,       32'hA0,      5'd10, 1, 4'd0);
        v(2'b00, 5'd10, 32'hCC,      4'd0, 5'd0, 32'h0,      4'd0, 0, 5'd0, 4'd0, 5'd10, 5'd0, 32'hA0,      32'h0,       5'd10, 1, 4'd0);
        v(2'b00, 5'd0, 32'h0,        4'd0, 5'd0, 32'h0,      4'd0, 1, 5'd0, 4'd9, 5'd0, 5'd0, 32'h0,        32'h0,       5'd0, 1, 4'd0);

        for (int i = 0; i < vq.size(); i++) begin
            write_en      = vq[i].we;
            write_addr[0] = vq[i].wa0; write_data[0] = vq[i].wd0; write_tag[0] = vq[i].wt0;
            write_addr[1] = vq[i].wa1; write_data[1] = vq[i].wd1; write_tag[1] = vq[i].wt1;
            alloc_en      = vq[i].ae;  alloc_addr    = vq[i].aa;  alloc_tag    = vq[i].at;
            read_addr[0]  = vq[i].ra0; read_addr[1]  = vq[i].ra1;
            step();
            $display("vec %0d: rd0=%h rd1=%h valid[%0d]=%b tag[%0d]=%h",
                     i, read_data[0], read_data[1], vq[i].ca, register_valid[vq[i].ca],
                     vq[i].ca, reg_tag_out[vq[i].ca]);
            chk($sformatf("vec%0d rd0", i), 128'(read_data[0]), 128'(vq[i].e0));
            chk($sformatf("vec%0d rd1", i), 128'(read_data[1]), 128'(vq[i].e1));
            chk($sformatf("vec%0d valid", i), 128'(register_valid[vq[i].ca]), 128'(vq[i].ev));
            chk($sformatf("vec%0d tag", i), 128'(reg_tag_out[vq[i].ca]), 128'(vq[i].et));
        end

        // Pending allocations, then reset together with alloc and write.
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd12; alloc_tag = 4'd9;
        step();
        $display("alloc x12: valid[12]=%b tag[12]=%h", register_valid[12], reg_tag_out[12]);
        chk("alloc x12 valid", 128'(register_valid[12]), 128'h0);
        chk("alloc x12 tag", 128'(reg_tag_out[12]), 128'h9);
        reset = 1'b1;
        alloc_en = 1'b1; alloc_addr = 5'd2; alloc_tag = 4'd4;
        write_en = 2'b01; write_addr[0] = 5'd9; write_data[0] = 32'h999; write_tag[0] = 4'd0;
        read_addr[0] = 5'd7; read_addr[1] = 5'd4;
        step();
        $display("reset w/ alloc: rd0=%h rd1=%h valid=%h", read_data[0], read_data[1], register_valid);
        chk("rst alloc valid", 128'(register_valid), 128'hFFFF_FFFF);
        chk("rst alloc tags", 128'(reg_tag_out), 128'h0);
        chk("rst alloc rd0", 128'(read_data[0]), 128'h0);
        chk("rst alloc rd1", 128'(read_data[1]), 128'h0);
        idle();
        reset = 1'b0;
        read_addr[0] = 5'd7; read_addr[1] = 5'd4;
        step();
        $display("after reset: rd0=%h rd1=%h", read_data[0], read_data[1]);
        chk("after rst x7", 128'(read_data[0]), 128'h33);
        chk("after rst x4", 128'(read_data[1]), 128'hDEAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
